accum_frame: RTL and testbench
==============================

# accum_frame

Sequential frame accumulator that sits directly downstream of the ADD datapath component. It accepts a stream of unsigned DATAWIDTH-bit operands over a valid/ready handshake and sums COUNT operands per frame through an internal ADD instance. It presents each frame total on a registered valid/ready output port. A sticky overflow flag accompanies each total.

## Interface
- DATAWIDTH, 2, operand/result width in bits (≥1)
- COUNT, 4, operands per frame (≥1)
- CNTW, derived = max(1, clog2(COUNT)), frame counter width; not overridden by users

- Clk  input  1  clock; all state updates on rising edge
- Rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data valid this cycle
- in_ready  output  1  block can accept an operand this cycle
- in_data  input  DATAWIDTH  unsigned operand
- out_valid  output  1  out_data holds a completed frame total
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  DATAWIDTH  frame total, registered
- ovf  output  1  at least one carry-out occurred in the current/presented frame

## Operation
- Two-state FSM: ACC, HOLD. Reset state ACC.
- Reset values: acc=0, cnt=0, out_valid=0, out_data=0, ovf=0; in_ready=0 while Rst high, 1 the cycle after Rst deasserts.
- in_ready = (state==ACC); out_valid = (state==HOLD). No combinational path from in_valid or out_ready to either.
- ACC, on accept (in_valid && in_ready):
  - first operand of frame (cnt==0): acc <= in_data, ovf <= 0.
  - otherwise: acc <= ADD(acc, in_data); ovf <= ovf | carry-out of the DATAWIDTH+1-bit sum.
  - cnt == COUNT-1: cnt <= 0, state <= HOLD; otherwise cnt <= cnt+1.
- ACC, no accept: all state held; in_valid gaps allowed anywhere in a frame.
- HOLD: out_data = acc and ovf are held stable while out_ready=0; in_data/in_valid ignored.
- HOLD with out_ready=1: state <= ACC, acc <= 0; ovf holds until the next frame's first operand clears it.
- COUNT=1: every accepted operand goes straight to HOLD with out_data=in_data, ovf=0.
- Rst mid-frame or during HOLD: partial sum and cnt discarded, pending total dropped, FSM returns to ACC.

## Timing
- Latency: out_valid rises on the cycle after the COUNT-th operand is accepted.
- Max throughput: one frame every COUNT+1 cycles. The handoff cycle (HOLD with out_ready=1) never accepts an input.
- in_ready is high on the cycle after an output handshake.
- Adder is purely combinational within the ACC cycle, so one operand is accepted per clock.

## Configuration
- ACCUM_SAT_EN defined: saturating add. On carry-out, acc <= all-ones and stays all-ones for the rest of the frame. ovf behaves as without the macro.
- ACCUM_SAT_EN undefined: sum wraps modulo 2^DATAWIDTH. ovf still reports the carry-out.

## Structure
- Shared package accum_pkg contains:
  - FSM state encoding constants ACC=1'b0, HOLD=1'b1.
  - The clog2 helper function used for CNTW.
- Sub-module: one ADD instance (DATAWIDTH+1 wide, MSB used as carry-out) for the accumulate path. Saturation muxing stays in accum_frame.

## Test plan
All scenarios use DATAWIDTH=8, COUNT=4 unless noted.
- Reset: hold Rst 2 cycles → out_valid=0, out_data=0, ovf=0, in_ready=0 during Rst, in_ready=1 the next cycle.
- Back-to-back: feed 1,2,3,4 on consecutive cycles → out_valid=1 the cycle after the 4th accept, out_data=10, ovf=0, in_ready=0.
- Backpressure: hold out_ready=0 for 5 cycles while driving in_valid=1, in_data=9 → out_data stays 10, no operand is accepted. Then raise out_ready for 1 cycle → in_ready=1 the next cycle, and the next frame starts fresh.
- Bubbles: feed 5,5,5,5 with in_valid low between each → out_data=20, latency is measured from the 4th accept.
- Overflow: feed 200,100,0,0 → without the macro out_data=44, ovf=1; with ACCUM_SAT_EN out_data=255, ovf=1. The next frame 1,1,1,1 gives out_data=4, ovf=0.
- Reset mid-frame: accept 7,7, pulse Rst, then feed 1,1,1,1 → out_data=4. With COUNT=1, feeding 3 gives out_valid the next cycle with out_data=3.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared definitions for the frame accumulator: FSM state encoding and the
// constant clog2 helper used to size the frame counter.
package accum_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = unsigned'(i + 1);
    end
    return res;
  endfunction

endpackage

// File: rtl/accum_frame_add.sv
// Plain combinational adder; the caller widens operands by one bit so the
// MSB of the result is the carry-out.
module accum_frame_add #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/accum_frame.sv
// Frame accumulator: sums COUNT operands per frame and presents the total with a
// sticky carry flag. Define ACCUM_SAT_EN for a saturating rather than wrapping sum.
module accum_frame
  import accum_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 2,
  parameter int unsigned COUNT     = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 ovf
);

  localparam int unsigned CNTW = (clog2(COUNT) > 1) ? clog2(COUNT) : 1;
  localparam logic [CNTW-1:0] LastCnt = CNTW'(COUNT - 1);

  state_e                 state_q, state_d;
  logic [DATAWIDTH-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  logic [DATAWIDTH:0]     sum;
  logic                   carry;
  logic [DATAWIDTH-1:0]   add_res;

  accum_frame_add #(
    .WIDTH(DATAWIDTH + 1)
  ) u_add (
    .a   ({1'b0, acc_q}),
    .b   ({1'b0, in_data}),
    .sum (sum)
  );

  assign carry = sum[DATAWIDTH];

`ifdef ACCUM_SAT_EN
  // Once saturated, further adds either carry again or add zero, so it sticks.
  assign add_res = carry ? '1 : sum[DATAWIDTH-1:0];
`else
  assign add_res = sum[DATAWIDTH-1:0];
`endif

  // Rst gates in_ready so no operand looks acceptable while reset is asserted.
  assign in_ready  = (state_q == ACC) && !Rst;
  assign out_valid = (state_q == HOLD);
  assign out_data  = acc_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ACC: begin
        if (in_valid) begin
          if (cnt_q == '0) begin
            acc_d = in_data;
            ovf_d = 1'b0;
          end else begin
            acc_d = add_res;
            ovf_d = ovf_q | carry;
          end
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACC;
          acc_d   = '0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_accum_frame.sv
// Directed bench for accum_frame (8-bit, 4 operands per frame, plus a 1-operand
// instance) checked against a frame-level arithmetic model every cycle.
module tb_accum_frame;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, ovf;
  logic [7:0] out_data;

  logic       in_valid1, out_ready1;
  logic       in_ready1, out_valid1, ovf1;
  logic [7:0] out_data1;

  int n_vec = 0;
  int n_err = 0;

  // Frame-level model state
  int   q[$];
  bit   m_known = 0;
  bit   m_hold  = 0;
  int   m_data  = 0;
  bit   m_ovf   = 0;

  always #5 clk = ~clk;

  accum_frame #(
    .DATAWIDTH(8),
    .COUNT    (4)
  ) u_dut (
    .Clk       (clk),
    .Rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf       (ovf)
  );

  accum_frame #(
    .DATAWIDTH(8),
    .COUNT    (1)
  ) u_dut1 (
    .Clk       (clk),
    .Rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_data  (out_data1),
    .ovf       (ovf1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one input vector; returns just after the edge that sampled it.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic o);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = o;
    @(posedge clk);
    #1;
  endtask

  function automatic int expect_total(input int tot);
`ifdef ACCUM_SAT_EN
    return (tot > 255) ? 255 : tot;
`else
    return tot % 256;
`endif
  endfunction

  // Compare process: check outputs against the model, then advance the model
  // with the inputs about to be sampled.
  initial begin
    int tot;
    forever begin
      @(negedge clk);
      if (m_known) begin
        chk("in_ready", int'(in_ready), int'(!rst && !m_hold));
        chk("out_valid", int'(out_valid), int'(m_hold));
        if (m_hold) begin
          chk("out_data", int'(out_data), m_data);
          chk("ovf", int'(ovf), int'(m_ovf));
        end
      end
      if (rst) begin
        q.delete();
        m_hold  = 0;
        m_known = 1;
      end else if (m_known) begin
        if (!m_hold && in_valid) begin
          q.push_back(int'(in_data));
          if (q.size() == 4) begin
            tot = 0;
            foreach (q[i]) tot += q[i];
            m_data = expect_total(tot);
            m_ovf  = (tot > 255);
            m_hold = 1;
            q.delete();
          end
        end else if (m_hold && out_ready) begin
          m_hold = 0;
        end
      end
    end
  end

  initial begin
    in_valid1  = 1'b0;
    out_ready1 = 1'b0;

    // Reset
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst in_ready", int'(in_ready), 0);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_data", int'(out_data), 0);
    chk("rst ovf", int'(ovf), 0);
    cyc(0, 0, 0, 0);
    chk("post-rst in_ready", int'(in_ready), 1);

    // Back-to-back frame
    cyc(0, 1, 1, 0);
    cyc(0, 1, 2, 0);
    cyc(0, 1, 3, 0);
    chk("b2b not yet valid", int'(out_valid), 0);
    cyc(0, 1, 4, 0);
    chk("b2b out_valid", int'(out_valid), 1);
    chk("b2b out_data", int'(out_data), 10);
    chk("b2b ovf", int'(ovf), 0);
    chk("b2b in_ready", int'(in_ready), 0);

    // Backpressure with in_valid asserted; nothing may be accepted
    for (int i = 0; i < 5; i++) cyc(0, 1, 9, 0);
    chk("bp out_data", int'(out_data), 10);
    chk("bp out_valid", int'(out_valid), 1);
    cyc(0, 1, 9, 1);
    chk("handoff in_ready", int'(in_ready), 1);
    chk("handoff out_valid", int'(out_valid), 0);

    // Bubbles between operands
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 5, 0);
      if (i < 3) cyc(0, 0, 0, 0);
    end
    chk("bubble out_valid", int'(out_valid), 1);
    chk("bubble out_data", int'(out_data), 20);
    chk("bubble ovf", int'(ovf), 0);
    cyc(0, 0, 0, 1);

    // Overflow
    cyc(0, 1, 200, 0);
    cyc(0, 1, 100, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
`ifdef ACCUM_SAT_EN
    chk("ovf out_data", int'(out_data), 255);
`else
    chk("ovf out_data", int'(out_data), 44);
`endif
    chk("ovf flag", int'(ovf), 1);
    cyc(0, 0, 0, 1);
    chk("ovf sticky past handoff", int'(ovf), 1);
    cyc(0, 1, 1, 0);
    chk("ovf cleared by first operand", int'(ovf), 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    chk("after ovf out_data", int'(out_data), 4);
    chk("after ovf flag", int'(ovf), 0);
    cyc(0, 0, 0, 1);

    // Reset mid-frame
    cyc(0, 1, 7, 0);
    cyc(0, 1, 7, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0);
    chk("midrst out_valid", int'(out_valid), 1);
    chk("midrst out_data", int'(out_data), 4);

    // Reset while holding a total
    cyc(1, 0, 0, 0);
    chk("holdrst out_valid", int'(out_valid), 0);
    cyc(0, 0, 0, 0);
    chk("holdrst in_ready", int'(in_ready), 1);

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 60; i++) begin
      cyc(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)));
    end
    cyc(0, 0, 0, 1);

    // COUNT=1 instance
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("c1 in_ready", int'(in_ready1), 1);
    in_valid1 = 1'b1;
    cyc(0, 0, 3, 0);
    in_valid1 = 1'b0;
    chk("c1 out_valid", int'(out_valid1), 1);
    chk("c1 out_data", int'(out_data1), 3);
    chk("c1 ovf", int'(ovf1), 0);
    chk("c1 busy", int'(in_ready1), 0);
    out_ready1 = 1'b1;
    cyc(0, 0, 0, 0);
    out_ready1 = 1'b0;
    chk("c1 handoff in_ready", int'(in_ready1), 1);
    chk("c1 handoff out_valid", int'(out_valid1), 0);

    cyc(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
